hdlc_rx_deframer: RTL and testbench
===================================

// Module: hdlc_rx_deframer
// PURPOSE
//  Bit-level HDLC receive front end between the serial Rx pin and the Rx controller/buffer.
//  - Detects flags (01111110) and aborts (0 then 7 ones).
//  - Removes inserted zeros and assembles LSB-first bytes.
//  - Frames the bytes with Rx_ValidFrame and end/error pulses for the downstream FCS/buffer stage.
// PARAMETERS
//  STUFF_ONES  5        consecutive ones after which a received 0 is a stuffed bit and is dropped
//  ABORT_ONES  7        ones after a 0 that constitute an abort
//  FLAG        8'h7E    flag pattern, compared LSB-first against the raw bit history
// PORTS
//  Clk            in   1  system clock; all logic on posedge
//  Rst            in   1  reset; synchronous, active-low
//  Rx             in   1  serial receive bit, one bit per Clk
//  RxEN           in   1  receiver enable; low = hold in IDLE, outputs cleared
//  Rx_FlagDetect  out  1  1-cycle pulse: flag recognised
//  Rx_AbortDetect out  1  1-cycle pulse: abort pattern recognised
//  Rx_ValidFrame  out  1  high between opening flag and closing flag/abort
//  Rx_NewByte     out  1  1-cycle pulse: Rx_Data holds a complete destuffed byte
//  Rx_Data        out  8  assembled byte; stable until the next Rx_NewByte
//  Rx_EndFrame    out  1  1-cycle pulse: frame closed by flag
//  Rx_FrameErr    out  1  1-cycle pulse with Rx_EndFrame: frame not byte-aligned
// BEHAVIOUR
//  Reset (Rst==0 at posedge)
//  - All outputs 0, Rx_Data 8'h00.
//  - Raw history all ones; ones counter 0; delay line valid tags 0; FSM to IDLE.
//  - Mid-frame reset: the frame is discarded silently, with no Rx_EndFrame.
//  - RxEN==0 has the same effect as reset.
//  Detection pipeline
//  - Stage 1: Rx is registered.
//  - Stage 2: the raw 8-bit history shifts and pattern compare registers.
//  - If the last flag bit is on Rx in cycle n, Rx_FlagDetect is high in cycle n+2 only.
//  - Abort (0 followed by ABORT_ONES ones): Rx_AbortDetect is high in cycle n+2 only.
//  - A run of ones longer than 7 does not re-trigger the abort (the pattern needs a leading 0).
//  - All-ones idle produces neither pulse.
//  - Overlapping (shared-zero) flags are each detected.
//  Zero removal
//  - A saturating ones counter runs on the raw stream.
//  - A 0 arriving when the counter == STUFF_ONES is dropped (no valid tag).
//  - Any 0 clears the counter.
//  Byte assembly
//  - Destuffed bits enter an 8-stage delay line with per-stage valid tags.
//  - A valid bit leaving the delay while in FRAME is shifted into Rx_Data LSB-first; a 3-bit counter advances.
//  - On the 8th bit: Rx_NewByte pulses next cycle; the counter wraps to 0.
//  - On any flag/abort detect the delay-line valid tags are cleared, so flag and abort bits are never emitted.
//  FSM
//  - IDLE: on FlagDetect go to FRAME; Rx_ValidFrame rises in cycle n+3.
//  - FRAME: FlagDetect with no completed byte and bit counter 0 is a repeated opening flag; stay in FRAME, no pulses.
//  - FRAME: FlagDetect otherwise goes to IDLE.
//    - Rx_ValidFrame falls in n+3; Rx_EndFrame pulses in n+3.
//    - Rx_FrameErr pulses with it if the bit counter != 0.
//    - The closing flag also serves as the next opening flag, so return directly to FRAME.
//  - FRAME: AbortDetect goes to IDLE; Rx_ValidFrame falls in n+3; no Rx_EndFrame; partial byte discarded.
//  - IDLE: AbortDetect pulses only.
//  - Simultaneous Rx_NewByte and closing flag cannot occur; the byte always precedes the flag by >=1 cycle.
// TESTING
//  1. Idle all ones for 100 cycles -> no FlagDetect, no AbortDetect, Rx_ValidFrame 0.
//  2. Flag, bytes 8'hA5 8'h3C, flag -> FlagDetect at n+2 for both flags.
//     Two Rx_NewByte with Rx_Data A5 then 3C; EndFrame pulse; FrameErr 0.
//  3. Flag, byte 8'hFF (stuffed 0 after 5 ones), 8'h7E (stuffed), flag -> Rx_Data FF then 7E.
//     No spurious FlagDetect inside the frame.
//  4. Flag, 8'h12, then 0+7 ones -> Rx_NewByte(12); AbortDetect at n+2.
//     ValidFrame falls n+3; no EndFrame.
//  5. Flag, 8'h55, 3 extra bits, flag -> one Rx_NewByte(55); EndFrame with FrameErr=1.
//  6. Rst low mid-frame for 1 cycle -> all outputs 0 the next cycle.
//     Next flag reopens the frame normally.

Source files
------------

// File: rtl/hdlc_rx_deframer.sv
// HDLC receive deframer: flag/abort detection, zero removal and LSB-first
// byte assembly between the serial Rx pin and the downstream FCS/buffer stage.
//
// Handshake: there is no backpressure. Rx carries one bit per Clk while RxEN
// is high. Rx_NewByte is a one-cycle strobe qualifying Rx_Data. Rx_Data holds
// its value until the next strobe. Rx_EndFrame and Rx_FrameErr are
// same-cycle strobes. Rx_ValidFrame is a level.
module hdlc_rx_deframer #(
   parameter int         STUFF_ONES = 5,
   parameter int         ABORT_ONES = 7,
   parameter logic [7:0] FLAG       = 8'h7E
) (
   input  logic       Clk,
   input  logic       Rst,
   input  logic       Rx,
   input  logic       RxEN,
   output logic       Rx_FlagDetect,
   output logic       Rx_AbortDetect,
   output logic       Rx_ValidFrame,
   output logic       Rx_NewByte,
   output logic [7:0] Rx_Data,
   output logic       Rx_EndFrame,
   output logic       Rx_FrameErr,
   output logic       dbg_state
);

   // A 0 followed by ABORT_ONES ones, oldest bit in the LSB.
   localparam logic [7:0] ABORT_PAT = 8'(((1 << ABORT_ONES) - 1) << 1);
   localparam logic [2:0] STUFF_CNT = 3'(STUFF_ONES);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_FRAME = 1'b1
   } state_t;

   // Stage 1 / stage 2 detection path
   logic       rx_q, rx_d;
   logic [6:0] hist_q, hist_d;        // previous seven raw bits, oldest in bit 0
   logic       flag_q, flag_d;
   logic       abort_q, abort_d;
   logic [2:0] ones_q, ones_d;        // saturating run of raw ones
   // Destuffed delay line: index 0 newest, index 7 leaves next
   logic [7:0] dl_bit_q, dl_bit_d;
   logic [7:0] dl_vld_q, dl_vld_d;
   // Byte assembly and framing
   state_t     state_q, state_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [6:0] shift_q, shift_d;      // first seven bits of the byte in progress
   logic       got_byte_q, got_byte_d;
   logic [7:0] data_q, data_d;
   logic       new_byte_q, new_byte_d;
   logic       valid_q, valid_d;
   logic       end_q, end_d;
   logic       err_q, err_d;

   logic [7:0] window;
   logic       drop;
   logic       det;
   logic       out_bit;
   logic       out_vld;
   logic       close;

   // Next-state logic for the whole receive path
   always_comb begin
      rx_d       = Rx;
      hist_d     = hist_q;
      flag_d     = 1'b0;
      abort_d    = 1'b0;
      ones_d     = ones_q;
      dl_bit_d   = dl_bit_q;
      dl_vld_d   = dl_vld_q;
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      got_byte_d = got_byte_q;
      data_d     = data_q;
      new_byte_d = 1'b0;
      valid_d    = 1'b0;
      end_d      = 1'b0;
      err_d      = 1'b0;
      close      = 1'b0;

      // Raw eight-bit window including the bit just registered
      window  = {rx_q, hist_q};
      hist_d  = window[7:1];
      flag_d  = (window == FLAG);
      abort_d = (window == ABORT_PAT);

      // A zero after exactly STUFF_ONES ones was inserted by the transmitter
      drop   = !rx_q && (ones_q == STUFF_CNT);
      ones_d = rx_q ? ((ones_q == 3'd7) ? 3'd7 : ones_q + 3'd1) : 3'd0;

      // Flag and abort bits are still in the delay line when detected;
      // dropping every tag keeps them out of the byte stream.
      det      = flag_q || abort_q;
      out_bit  = dl_bit_q[7];
      out_vld  = dl_vld_q[7] && !det;
      dl_bit_d = {dl_bit_q[6:0], rx_q};
      dl_vld_d = det ? {7'b0, !drop} : {dl_vld_q[6:0], !drop};

      if ((state_q == ST_FRAME) && out_vld) begin
         bit_cnt_d = bit_cnt_q + 3'd1;
         shift_d   = {out_bit, shift_q[6:1]};
         if (bit_cnt_q == 3'd7) begin
            data_d     = {out_bit, shift_q};
            new_byte_d = 1'b1;
            got_byte_d = 1'b1;
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (flag_q) begin
               state_d    = ST_FRAME;
               bit_cnt_d  = 3'd0;
               got_byte_d = 1'b0;
            end
         end
         ST_FRAME: begin
            if (flag_q) begin
               // Empty frame: just another opening flag.
               if (got_byte_q || (bit_cnt_q != 3'd0)) begin
                  // Closing flag doubles as the next opener, so stay in FRAME
                  // and only drop ValidFrame for one cycle.
                  close      = 1'b1;
                  end_d      = 1'b1;
                  err_d      = (bit_cnt_q != 3'd0);
                  bit_cnt_d  = 3'd0;
                  got_byte_d = 1'b0;
               end
            end else if (abort_q) begin
               state_d    = ST_IDLE;
               bit_cnt_d  = 3'd0;
               got_byte_d = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      valid_d = (state_d == ST_FRAME) && !close;
   end

   // Register everything; RxEN low behaves exactly like reset
   always_ff @(posedge Clk) begin
      if (!Rst || !RxEN) begin
         rx_q       <= 1'b1;
         hist_q     <= 7'h7F;
         flag_q     <= 1'b0;
         abort_q    <= 1'b0;
         ones_q     <= 3'd0;
         dl_bit_q   <= 8'h00;
         dl_vld_q   <= 8'h00;
         state_q    <= ST_IDLE;
         bit_cnt_q  <= 3'd0;
         shift_q    <= 7'h00;
         got_byte_q <= 1'b0;
         data_q     <= 8'h00;
         new_byte_q <= 1'b0;
         valid_q    <= 1'b0;
         end_q      <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         rx_q       <= rx_d;
         hist_q     <= hist_d;
         flag_q     <= flag_d;
         abort_q    <= abort_d;
         ones_q     <= ones_d;
         dl_bit_q   <= dl_bit_d;
         dl_vld_q   <= dl_vld_d;
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         got_byte_q <= got_byte_d;
         data_q     <= data_d;
         new_byte_q <= new_byte_d;
         valid_q    <= valid_d;
         end_q      <= end_d;
         err_q      <= err_d;
      end
   end

   assign Rx_FlagDetect  = flag_q;
   assign Rx_AbortDetect = abort_q;
   assign Rx_ValidFrame  = valid_q;
   assign Rx_NewByte     = new_byte_q;
   assign Rx_Data        = data_q;
   assign Rx_EndFrame    = end_q;
   assign Rx_FrameErr    = err_q;
   assign dbg_state      = state_q;

endmodule

// File: tb/tb_hdlc_rx_deframer.sv
// Bench for hdlc_rx_deframer: directed frames plus randomized frames checked
// against a bit-stream reference model built from the framing rules.
module tb_hdlc_rx_deframer;

   localparam int MAXC = 16384;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx = 1'b1;
   logic       rx_en = 1'b1;
   logic       flag_det, abort_det, valid_frame, new_byte, end_frame, frame_err, dbg_state;
   logic [7:0] rx_data;

   hdlc_rx_deframer dut (
      .Clk           (clk),
      .Rst           (rst_n),
      .Rx            (rx),
      .RxEN          (rx_en),
      .Rx_FlagDetect (flag_det),
      .Rx_AbortDetect(abort_det),
      .Rx_ValidFrame (valid_frame),
      .Rx_NewByte    (new_byte),
      .Rx_Data       (rx_data),
      .Rx_EndFrame   (end_frame),
      .Rx_FrameErr   (frame_err),
      .dbg_state     (dbg_state)
   );

   // Clock
   always #5 clk = ~clk;

   // Scoreboard state
   int         n_cmp = 0;
   int         n_err = 0;
   int         cyc = 0;
   bit         exp_flag[MAXC];
   bit         exp_abort[MAXC];
   bit         exp_end[MAXC];
   bit         exp_err[MAXC];
   bit         exp_vf[MAXC];
   logic [7:0] exp_q[$];
   bit         last_rst = 1'b0;

   // Reference model state
   typedef struct {
      int idx;
      bit b;
   } dbit_t;
   bit         raw_q[$];
   int         ones_run = 0;
   dbit_t      dq[$];
   bit         in_frame = 1'b0;
   int         nbits = 0;
   logic [7:0] acc = 8'h00;
   int         tx_ones = 0;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   function automatic void set_exp(input int c, input int kind, input bit v);
      if (c < MAXC) begin
         case (kind)
            0: exp_flag[c] = v;
            1: exp_abort[c] = v;
            2: exp_end[c] = v;
            3: exp_err[c] = v;
            default: exp_vf[c] = v;
         endcase
      end
   endfunction

   // A data bit joins the frame's byte stream, LSB first
   function automatic void commit(input bit b);
      if (in_frame) begin
         acc = {b, acc[7:1]};
         nbits++;
         if ((nbits % 8) == 0) exp_q.push_back(acc);
      end
   endfunction

   // One raw bit presented in cycle t
   task automatic model_bit(input int t, input bit b);
      bit    is_flag, is_abort, dropped;
      int    lim;
      dbit_t d;
      raw_q.push_back(b);
      raw_q.delete(0);
      is_flag = (raw_q[0] == 1'b0) && (raw_q[7] == 1'b0);
      for (int k = 1; k < 7; k++) if (raw_q[k] != 1'b1) is_flag = 1'b0;
      is_abort = (raw_q[0] == 1'b0);
      for (int k = 1; k < 8; k++) if (raw_q[k] != 1'b1) is_abort = 1'b0;
      dropped  = (b == 1'b0) && (ones_run == 5);
      ones_run = b ? ones_run + 1 : 0;
      if (!dropped) begin
         d.idx = t;
         d.b   = b;
         dq.push_back(d);
      end
      // A bit is known to be data once no flag/abort can still contain it
      lim = (is_flag || is_abort) ? t - 8 : t - 7;
      while (dq.size() > 0 && dq[0].idx <= lim) begin
         commit(dq[0].b);
         dq.delete(0);
      end
      if (is_flag || is_abort) dq.delete();
      if (is_flag) set_exp(t + 2, 0, 1'b1);
      if (is_abort) set_exp(t + 2, 1, 1'b1);
      if (is_flag) begin
         if (!in_frame) begin
            in_frame = 1'b1;
            nbits    = 0;
            set_exp(t + 3, 4, 1'b1);
         end else if (nbits == 0) begin
            set_exp(t + 3, 4, 1'b1);
         end else begin
            set_exp(t + 3, 2, 1'b1);
            set_exp(t + 3, 3, (nbits % 8) != 0);
            set_exp(t + 3, 4, 1'b0);
            nbits = 0;
         end
      end else if (is_abort) begin
         in_frame = 1'b0;
         nbits    = 0;
         set_exp(t + 3, 4, 1'b0);
      end else begin
         set_exp(t + 3, 4, in_frame);
      end
   endtask

   // Reset (or RxEN low) sampled at the end of cycle r
   task automatic model_reset(input int r);
      for (int c = r + 1; c <= r + 3; c++) begin
         for (int k = 0; k < 5; k++) set_exp(c, k, 1'b0);
      end
      raw_q.delete();
      for (int k = 0; k < 8; k++) raw_q.push_back(1'b1);
      ones_run = 0;
      dq.delete();
      in_frame = 1'b0;
      nbits    = 0;
   endtask

   // Driver: present one cycle of inputs, then check outputs at negedge
   task automatic drive(input bit b, input bit rn, input bit en);
      if (cyc >= MAXC - 4) begin
         $display("FAIL cycle_budget cyc=%0d got=%0d exp<%0d", cyc, cyc, MAXC - 4);
         n_err++;
         $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
         $fatal(1, "cycle budget exhausted");
      end
      rx    = b;
      rst_n = rn;
      rx_en = en;
      if (rn && en) model_bit(cyc, b);
      else model_reset(cyc);
      @(negedge clk);
      if (cyc > 0) begin
         chk("flag_det", flag_det, exp_flag[cyc]);
         chk("abort_det", abort_det, exp_abort[cyc]);
         chk("end_frame", end_frame, exp_end[cyc]);
         chk("frame_err", frame_err, exp_err[cyc]);
         chk("valid_frame", valid_frame, exp_vf[cyc]);
         if (new_byte === 1'b1) begin
            if (exp_q.size() == 0) chk("new_byte_extra", new_byte, 8'h00);
            else chk("rx_data", rx_data, exp_q.pop_front());
         end
         if (last_rst) chk("rst_data", rx_data, 8'h00);
      end
      last_rst = !(rn && en);
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic send_idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b1, 1'b1, 1'b1);
      tx_ones = 0;
   endtask

   task automatic send_flag();
      drive(1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, 1'b1);
      drive(1'b0, 1'b1, 1'b1);
      tx_ones = 0;
   endtask

   // Second flag sharing the previous flag's closing zero
   task automatic send_flag_shared();
      for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, 1'b1);
      drive(1'b0, 1'b1, 1'b1);
      tx_ones = 0;
   endtask

   task automatic send_abort();
      drive(1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 7; i++) drive(1'b1, 1'b1, 1'b1);
      tx_ones = 0;
   endtask

   // LSB-first data bits with a zero inserted after five ones
   task automatic send_bits(input logic [7:0] v, input int n);
      for (int i = 0; i < n; i++) begin
         drive(v[i], 1'b1, 1'b1);
         tx_ones = v[i] ? tx_ones + 1 : 0;
         if (tx_ones == 5) begin
            drive(1'b0, 1'b1, 1'b1);
            tx_ones = 0;
         end
      end
   endtask

   task automatic reset_mid_frame(input bit use_en);
      send_flag();
      send_bits(8'($urandom_range(0, 255)), 8);
      send_bits(8'($urandom_range(0, 255)), 8);
      send_bits(8'($urandom_range(0, 255)), 4);
      if (use_en) drive(1'b1, 1'b1, 1'b0);
      else drive(1'b1, 1'b0, 1'b1);
      send_idle(12);
      send_flag();
      send_bits(8'hC3, 8);
      send_flag();
      send_idle(10);
   endtask

   initial begin
      int  nb;
      int  extra;
      bit  open_tx;
      for (int k = 0; k < MAXC; k++) begin
         exp_flag[k]  = 1'b0;
         exp_abort[k] = 1'b0;
         exp_end[k]   = 1'b0;
         exp_err[k]   = 1'b0;
         exp_vf[k]    = 1'b0;
      end
      for (int k = 0; k < 8; k++) raw_q.push_back(1'b1);
      @(posedge clk);
      #1;

      // Reset, then long all-ones idle
      repeat (3) drive(1'b1, 1'b0, 1'b1);
      chk("rst_state", dbg_state, 8'h00);
      send_idle(100);

      // Two plain bytes
      send_flag();
      send_bits(8'hA5, 8);
      send_bits(8'h3C, 8);
      send_flag();
      send_idle(12);

      // Bytes that need zero insertion
      send_flag();
      send_bits(8'hFF, 8);
      send_bits(8'h7E, 8);
      send_flag();
      send_idle(12);

      // Abort after one byte
      send_flag();
      send_bits(8'h12, 8);
      send_abort();
      send_idle(12);

      // Misaligned frame
      send_flag();
      send_bits(8'h55, 8);
      send_bits(8'h05, 3);
      send_flag();
      send_idle(12);

      // Mid-frame reset, then mid-frame receiver disable
      reset_mid_frame(1'b0);
      reset_mid_frame(1'b1);

      // Randomized frames
      open_tx = 1'b0;
      for (int f = 0; f < 40; f++) begin
         if (!open_tx) begin
            send_flag();
            if ($urandom_range(0, 3) == 0) send_flag_shared();
            else if ($urandom_range(0, 3) == 0) send_flag();
         end
         nb    = $urandom_range(1, 4);
         extra = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0;
         for (int i = 0; i < nb; i++) send_bits(8'($urandom_range(0, 255)), 8);
         if (extra > 0) send_bits(8'($urandom_range(0, 255)), extra);
         if ($urandom_range(0, 4) == 0) begin
            send_abort();
            open_tx = 1'b0;
            send_idle($urandom_range(0, 12));
         end else begin
            send_flag();
            open_tx = ($urandom_range(0, 1) == 1);
            if (!open_tx) send_idle($urandom_range(0, 12));
         end
      end
      send_idle(20);

      chk("bytes_left", 8'(exp_q.size()), 8'h00);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
